// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: run-state enum and decode-mode constants shared with the control decoder
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} run_state_t;

    localparam logic [1:0] MODE_REG    = 2'b00;
    localparam logic [1:0] MODE_TARGET = 2'b01;
    localparam logic [1:0] MODE_IMM    = 2'b10;
    localparam logic [1:0] MODE_NOP    = 2'b11;

    // The NOP mode is deprecated; the sequencer replaces it with plain register mode
    function automatic logic [1:0] fold_mode(input logic [1:0] m);
        return (m == MODE_NOP) ? MODE_REG : m;
    endfunction

endpackage

// File: rtl/fetch_sequencer_prog_ctr.sv
// prog_ctr: program counter register with load > branch > increment > hold priority
module prog_ctr #(
    parameter int PC_W = 9
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            load,
    input  logic [PC_W-1:0] load_addr,
    input  logic            branch,
    input  logic [PC_W-1:0] branch_target,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge Clk) begin
        if (!Reset)
            pc <= '0;
        else
            pc <= load ? load_addr : branch ? branch_target : inc ? pc + PC_W'(1) : pc;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: run FSM, mode/previous-instruction registers and cycle counter feeding the control decoder
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             BranchEn,
    input  logic [PC_W-1:0]  BranchTarget,
    input  logic             Ack,
    input  logic [1:0]       NextState,
    input  logic [8:0]       PrevInstructionOut,
    output logic [PC_W-1:0]  ProgCtr,
    output logic [1:0]       CurrState,
    output logic [8:0]       PrevInstruction,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    run_state_t state, state_nxt;
    logic       advance;
    logic       step;

    always_comb begin
        state_nxt = Start ? ARM
                  : (state == ARM) ? RUN
                  : (state == RUN && Ack) ? DONE
                  : state;
    end

    assign advance = (state == RUN) && !Start;
    // Ack freezes the program state so the completing instruction stays visible in DONE
    assign step    = advance && !Ack;
    assign Running = (state == RUN);
    assign Done    = (state == DONE);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state           <= IDLE;
            CurrState       <= MODE_REG;
            PrevInstruction <= '0;
            CycleCount      <= '0;
        end else begin
            state <= state_nxt;
            if (Start) begin
                CurrState       <= MODE_REG;
                PrevInstruction <= '0;
                CycleCount      <= '0;
            end else if (advance) begin
                CycleCount <= (CycleCount == '1) ? CycleCount : CycleCount + CNT_W'(1);
                if (step) begin
                    CurrState       <= fold_mode(NextState);
                    PrevInstruction <= PrevInstructionOut;
                end
            end
        end
    end

    prog_ctr #(.PC_W(PC_W)) u_prog_ctr (
        .Clk           (Clk),
        .Reset         (Reset),
        .load          (Start),
        .load_addr     (StartAddr),
        .branch        (step && BranchEn),
        .branch_target (BranchTarget),
        .inc           (step),
        .pc            (ProgCtr)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenario tasks with hand-computed expectations for fetch_sequencer
module tb_fetch_sequencer;

    logic        Clk = 0;
    logic        Reset = 0;
    logic        Start = 0;
    logic [8:0]  StartAddr = 0;
    logic        BranchEn = 0;
    logic [8:0]  BranchTarget = 0;
    logic        Ack = 0;
    logic [1:0]  NextState = 0;
    logic [8:0]  PrevInstructionOut = 0;
    logic [8:0]  ProgCtr;
    logic [1:0]  CurrState;
    logic [8:0]  PrevInstruction;
    logic        Running;
    logic        Done;
    logic [15:0] CycleCount;

    int vectors = 0;
    int miscompares = 0;

    fetch_sequencer #(.PC_W(9), .CNT_W(16)) dut (
        .Clk                (Clk),
        .Reset              (Reset),
        .Start              (Start),
        .StartAddr          (StartAddr),
        .BranchEn           (BranchEn),
        .BranchTarget       (BranchTarget),
        .Ack                (Ack),
        .NextState          (NextState),
        .PrevInstructionOut (PrevInstructionOut),
        .ProgCtr            (ProgCtr),
        .CurrState          (CurrState),
        .PrevInstruction    (PrevInstruction),
        .Running            (Running),
        .Done               (Done),
        .CycleCount         (CycleCount)
    );

    always #5 Clk = ~Clk;

    // Observation bundle: {Running, Done, CurrState, ProgCtr, PrevInstruction, CycleCount}
    function automatic logic [37:0] obs();
        return {Running, Done, CurrState, ProgCtr, PrevInstruction, CycleCount};
    endfunction

    function automatic logic [37:0] ex(input logic r, input logic d, input logic [1:0] cs,
                                       input logic [8:0] pc, input logic [8:0] pi, input logic [15:0] cc);
        return {r, d, cs, pc, pi, cc};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 0;
        step();
        step();
        vectors++;
        if (obs() !== ex(0, 0, 2'b00, 9'h000, 9'h000, 16'd0)) begin
            miscompares++;
            $display("FAIL reset got %h expected %h", obs(), ex(0, 0, 2'b00, 9'h000, 9'h000, 16'd0));
        end
        Reset = 1;
        step();
        vectors++;
        if (obs() !== ex(0, 0, 2'b00, 9'h000, 9'h000, 16'd0)) begin
            miscompares++;
            $display("FAIL idle_hold got %h expected %h", obs(), ex(0, 0, 2'b00, 9'h000, 9'h000, 16'd0));
        end
    endtask

    task automatic test_launch();
        Start = 1;
        StartAddr = 9'h010;
        step();
        vectors++;
        if (obs() !== ex(0, 0, 2'b00, 9'h010, 9'h000, 16'd0)) begin
            miscompares++;
            $display("FAIL launch_arm got %h expected %h", obs(), ex(0, 0, 2'b00, 9'h010, 9'h000, 16'd0));
        end
        Start = 0;
        StartAddr = 9'h1AB;
        step();
        vectors++;
        if (obs() !== ex(1, 0, 2'b00, 9'h010, 9'h000, 16'd0)) begin
            miscompares++;
            $display("FAIL launch_run0 got %h expected %h", obs(), ex(1, 0, 2'b00, 9'h010, 9'h000, 16'd0));
        end
        step();
        vectors++;
        if (obs() !== ex(1, 0, 2'b00, 9'h011, 9'h000, 16'd1)) begin
            miscompares++;
            $display("FAIL launch_run1 got %h expected %h", obs(), ex(1, 0, 2'b00, 9'h011, 9'h000, 16'd1));
        end
        step();
        vectors++;
        if (obs() !== ex(1, 0, 2'b00, 9'h012, 9'h000, 16'd2)) begin
            miscompares++;
            $display("FAIL launch_run2 got %h expected %h", obs(), ex(1, 0, 2'b00, 9'h012, 9'h000, 16'd2));
        end
    endtask

    task automatic test_branch();
        BranchEn = 1;
        BranchTarget = 9'h0A5;
        step();
        vectors++;
        if (obs() !== ex(1, 0, 2'b00, 9'h0A5, 9'h000, 16'd3)) begin
            miscompares++;
            $display("FAIL branch_take got %h expected %h", obs(), ex(1, 0, 2'b00, 9'h0A5, 9'h000, 16'd3));
        end
        BranchEn = 0;
        step();
        vectors++;
        if (obs() !== ex(1, 0, 2'b00, 9'h0A6, 9'h000, 16'd4)) begin
            miscompares++;
            $display("FAIL branch_next got %h expected %h", obs(), ex(1, 0, 2'b00, 9'h0A6, 9'h000, 16'd4));
        end
    endtask

    task automatic test_mode();
        NextState = 2'b01;
        PrevInstructionOut = 9'h1E0;
        step();
        vectors++;
        if (obs() !== ex(1, 0, 2'b01, 9'h0A7, 9'h1E0, 16'd5)) begin
            miscompares++;
            $display("FAIL mode_target got %h expected %h", obs(), ex(1, 0, 2'b01, 9'h0A7, 9'h1E0, 16'd5));
        end
        NextState = 2'b11;
        PrevInstructionOut = 9'h055;
        step();
        vectors++;
        if (obs() !== ex(1, 0, 2'b00, 9'h0A8, 9'h055, 16'd6)) begin
            miscompares++;
            $display("FAIL mode_nop_fold got %h expected %h", obs(), ex(1, 0, 2'b00, 9'h0A8, 9'h055, 16'd6));
        end
        NextState = 2'b10;
        step();
        vectors++;
        if (obs() !== ex(1, 0, 2'b10, 9'h0A9, 9'h055, 16'd7)) begin
            miscompares++;
            $display("FAIL mode_imm got %h expected %h", obs(), ex(1, 0, 2'b10, 9'h0A9, 9'h055, 16'd7));
        end
        NextState = 2'b00;
    endtask

    task automatic test_wrap_ack();
        BranchEn = 1;
        BranchTarget = 9'h1FE;
        step();
        BranchEn = 0;
        step();
        vectors++;
        if (obs() !== ex(1, 0, 2'b00, 9'h1FF, 9'h055, 16'd9)) begin
            miscompares++;
            $display("FAIL wrap_top got %h expected %h", obs(), ex(1, 0, 2'b00, 9'h1FF, 9'h055, 16'd9));
        end
        step();
        vectors++;
        if (obs() !== ex(1, 0, 2'b00, 9'h000, 9'h055, 16'd10)) begin
            miscompares++;
            $display("FAIL wrap_zero got %h expected %h", obs(), ex(1, 0, 2'b00, 9'h000, 9'h055, 16'd10));
        end
        Ack = 1;
        BranchEn = 1;
        BranchTarget = 9'h123;
        NextState = 2'b10;
        PrevInstructionOut = 9'h1AA;
        step();
        vectors++;
        if (obs() !== ex(0, 1, 2'b00, 9'h000, 9'h055, 16'd11)) begin
            miscompares++;
            $display("FAIL ack_done got %h expected %h", obs(), ex(0, 1, 2'b00, 9'h000, 9'h055, 16'd11));
        end
        Ack = 0;
        BranchEn = 0;
        step();
        step();
        vectors++;
        if (obs() !== ex(0, 1, 2'b00, 9'h000, 9'h055, 16'd11)) begin
            miscompares++;
            $display("FAIL done_hold got %h expected %h", obs(), ex(0, 1, 2'b00, 9'h000, 9'h055, 16'd11));
        end
        NextState = 2'b00;
        PrevInstructionOut = 9'h000;
    endtask

    task automatic test_reset_midrun();
        Start = 1;
        StartAddr = 9'h030;
        step();
        Start = 0;
        PrevInstructionOut = 9'h0C3;
        step();
        step();
        step();
        step();
        vectors++;
        if (obs() !== ex(1, 0, 2'b00, 9'h033, 9'h0C3, 16'd3)) begin
            miscompares++;
            $display("FAIL midrun_pre got %h expected %h", obs(), ex(1, 0, 2'b00, 9'h033, 9'h0C3, 16'd3));
        end
        Reset = 0;
        step();
        vectors++;
        if (obs() !== ex(0, 0, 2'b00, 9'h000, 9'h000, 16'd0)) begin
            miscompares++;
            $display("FAIL midrun_reset got %h expected %h", obs(), ex(0, 0, 2'b00, 9'h000, 9'h000, 16'd0));
        end
        Reset = 1;
        step();
        step();
        vectors++;
        if (obs() !== ex(0, 0, 2'b00, 9'h000, 9'h000, 16'd0)) begin
            miscompares++;
            $display("FAIL midrun_idle got %h expected %h", obs(), ex(0, 0, 2'b00, 9'h000, 9'h000, 16'd0));
        end
        PrevInstructionOut = 9'h000;
    endtask

    task automatic test_restart();
        Start = 1;
        StartAddr = 9'h100;
        step();
        Start = 0;
        step();
        NextState = 2'b01;
        PrevInstructionOut = 9'h0FF;
        step();
        vectors++;
        if (obs() !== ex(1, 0, 2'b01, 9'h101, 9'h0FF, 16'd1)) begin
            miscompares++;
            $display("FAIL restart_run got %h expected %h", obs(), ex(1, 0, 2'b01, 9'h101, 9'h0FF, 16'd1));
        end
        Start = 1;
        StartAddr = 9'h040;
        step();
        vectors++;
        if (obs() !== ex(0, 0, 2'b00, 9'h040, 9'h000, 16'd0)) begin
            miscompares++;
            $display("FAIL abort_arm got %h expected %h", obs(), ex(0, 0, 2'b00, 9'h040, 9'h000, 16'd0));
        end
        Start = 0;
        step();
        vectors++;
        if (obs() !== ex(1, 0, 2'b00, 9'h040, 9'h000, 16'd0)) begin
            miscompares++;
            $display("FAIL abort_relaunch got %h expected %h", obs(), ex(1, 0, 2'b00, 9'h040, 9'h000, 16'd0));
        end
        Ack = 1;
        step();
        vectors++;
        if (obs() !== ex(0, 1, 2'b00, 9'h040, 9'h000, 16'd1)) begin
            miscompares++;
            $display("FAIL single_ack got %h expected %h", obs(), ex(0, 1, 2'b00, 9'h040, 9'h000, 16'd1));
        end
        Ack = 0;
        NextState = 2'b00;
        Start = 1;
        StartAddr = 9'h1F0;
        step();
        vectors++;
        if (obs() !== ex(0, 0, 2'b00, 9'h1F0, 9'h000, 16'd0)) begin
            miscompares++;
            $display("FAIL done_rearm got %h expected %h", obs(), ex(0, 0, 2'b00, 9'h1F0, 9'h000, 16'd0));
        end
        Start = 0;
        step();
        step();
        vectors++;
        if (obs() !== ex(1, 0, 2'b00, 9'h1F1, 9'h0FF, 16'd1)) begin
            miscompares++;
            $display("FAIL done_rerun got %h expected %h", obs(), ex(1, 0, 2'b00, 9'h1F1, 9'h0FF, 16'd1));
        end
    endtask

    initial begin
        test_reset();
        test_launch();
        test_branch();
        test_mode();
        test_wrap_ack();
        test_reset_midrun();
        test_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
